// File: rtl/alu_result_stage.sv
// EX->WB result stage: two-entry main/skid buffer between ALU and write-back.
// in_ready is decoded from the state register only, so write-back stalls never reach the ALU combinationally.
module alu_result_stage #(
    parameter int N  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  result,
    input  logic [RW-1:0] rd,
    input  logic          we,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          out_zero,
    output logic          out_neg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [N-1:0]  res;
        logic [RW-1:0] rd;
        logic          we;
        logic          zero;
        logic          neg;
    } entry_t;

    state_t state, state_nx;
    entry_t main_q, skid_q, in_e;
    logic   acc, take;
    logic   ld_main, ld_skid, mv_skid;

    // Flags are computed once at capture; x0 writes are squashed here.
    always_comb begin
        in_e.res  = result;
        in_e.rd   = rd;
        in_e.we   = we & (|rd);
        in_e.zero = ~|result;
        in_e.neg  = result[N-1];
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld_main  = 1'b0;
        ld_skid  = 1'b0;
        mv_skid  = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nx = ONE;
                        ld_main  = 1'b1;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        acc && take: ld_main = 1'b1;
                        acc && !take: begin
                            state_nx = TWO;
                            ld_skid  = 1'b1;
                        end
                        !acc && take: state_nx = EMPTY;
                        default: state_nx = ONE;
                    endcase
                end
                TWO: begin
                    if (take) begin
                        state_nx = ONE;
                        mv_skid  = 1'b1;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main)      main_q <= in_e;
            else if (mv_skid) main_q <= skid_q;
            if (ld_skid)      skid_q <= in_e;
        end
    end

    // Main may hold a stale entry after a take or flush; never expose its write enable.
    assign out_result = main_q.res;
    assign out_rd     = main_q.rd;
    assign out_we     = main_q.we & out_valid;
    assign out_zero   = main_q.zero;
    assign out_neg    = main_q.neg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with an occupancy model and expected-entry queue.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        run = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we, out_zero, out_neg;

    int errors = 0;
    int checks = 0;
    int cnt    = 0;
    logic [39:0] q[$];

    always #5 if (run) clk = ~clk;

    alu_result_stage #(.N(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .rd(rd), .we(we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_we(out_we), .out_zero(out_zero), .out_neg(out_neg)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [31:0] r,
                                       input logic [4:0] d, input logic w);
        return {r, d, w & (d != 5'd0), r == 32'd0, r[31]};
    endfunction

    task automatic chk_out(input string tag);
        logic [39:0] e;
        chk({tag, ".valid"}, 64'(out_valid), 64'(cnt > 0));
        chk({tag, ".ready"}, 64'(in_ready), 64'(cnt < 2));
        if (cnt > 0) begin
            e = q[0];
            chk({tag, ".result"}, 64'(out_result), 64'(e[39:8]));
            chk({tag, ".rd"}, 64'(out_rd), 64'(e[7:3]));
            chk({tag, ".we"}, 64'(out_we), 64'(e[2]));
            chk({tag, ".zero"}, 64'(out_zero), 64'(e[1]));
            chk({tag, ".neg"}, 64'(out_neg), 64'(e[0]));
        end else begin
            chk({tag, ".we_idle"}, 64'(out_we), 64'd0);
        end
    endtask

    task automatic cyc(input string tag, input logic iv, input logic [31:0] r,
                       input logic [4:0] d, input logic w,
                       input logic ordy, input logic fl);
        logic acc, tk;
        @(negedge clk);
        in_valid  = iv;
        result    = r;
        rd        = d;
        we        = w;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk({tag, ".ready_pre"}, 64'(in_ready), 64'(cnt < 2));
        acc = iv && (cnt < 2) && !fl;
        tk  = (cnt > 0) && ordy && !fl;
        if (fl) begin
            q.delete();
            cnt = 0;
        end else begin
            if (tk) begin
                void'(q.pop_front());
                cnt--;
            end
            if (acc) begin
                q.push_back(mk(r, d, w));
                cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk_out(tag);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".result"}, 64'(out_result), 64'd0);
        chk({tag, ".rd"}, 64'(out_rd), 64'd0);
        chk({tag, ".we"}, 64'(out_we), 64'd0);
        chk({tag, ".zero"}, 64'(out_zero), 64'd0);
        chk({tag, ".neg"}, 64'(out_neg), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        result = '0; rd = '0; we = 1'b0; out_ready = 1'b0;
        #2;
        reset_chk("rst0");
        rst = 1'b0;
        run = 1'b1;

        // streaming
        cyc("s1", 1, 32'h11, 5'd1, 1, 1, 0);
        cyc("s2", 1, 32'h22, 5'd2, 1, 1, 0);
        cyc("s3", 1, 32'h33, 5'd3, 1, 1, 0);
        cyc("s4", 0, 32'h0, 5'd0, 0, 1, 0);

        // back-pressure then drain
        cyc("b1", 1, 32'hA, 5'd4, 1, 0, 0);
        cyc("b2", 1, 32'hB, 5'd4, 1, 0, 0);
        cyc("b3", 1, 32'hC, 5'd4, 1, 0, 0);
        cyc("b4", 1, 32'hC, 5'd4, 1, 0, 0);
        cyc("b5", 1, 32'hC, 5'd4, 1, 1, 0);
        cyc("b6", 1, 32'hC, 5'd4, 1, 1, 0);
        cyc("b7", 0, 32'h0, 5'd0, 0, 1, 0);
        cyc("b8", 0, 32'h0, 5'd0, 0, 1, 0);

        // flush in TWO with an accept attempt
        cyc("f1", 1, 32'hD1, 5'd6, 1, 0, 0);
        cyc("f2", 1, 32'hD2, 5'd7, 1, 0, 0);
        cyc("f3", 1, 32'hD3, 5'd8, 1, 1, 1);
        chk("f3.we_direct", 64'(out_we), 64'd0);
        cyc("f4", 0, 32'h0, 5'd0, 0, 1, 0);
        cyc("f5", 1, 32'h77, 5'd9, 1, 1, 0);
        cyc("f6", 0, 32'h0, 5'd0, 0, 1, 0);

        // flags and x0 handling
        cyc("g1", 1, 32'h0, 5'd3, 1, 1, 0);
        cyc("g2", 1, 32'h8000_0000, 5'd3, 1, 1, 0);
        cyc("g3", 1, 32'h1234, 5'd0, 1, 1, 0);
        cyc("g4", 1, 32'h5678, 5'd5, 1, 1, 0);
        cyc("g5", 1, 32'hFFFF_FFFF, 5'd31, 0, 1, 0);
        cyc("g6", 0, 32'h0, 5'd0, 0, 1, 0);

        // asynchronous reset mid-operation
        cyc("r1", 1, 32'hE1, 5'd1, 1, 0, 0);
        cyc("r2", 1, 32'hE2, 5'd2, 1, 0, 0);
        #1 rst = 1'b1;
        #1;
        reset_chk("rst1");
        rst = 1'b0;
        q.delete();
        cnt = 0;
        cyc("r3", 1, 32'h55, 5'd10, 1, 1, 0);
        cyc("r4", 0, 32'h0, 5'd0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
